// File: rtl/seed_tree_reconstruct.sv
// rtl/seed_tree_reconstruct.sv - verifier-side 4-leaf seed-tree rebuild from two co-path seeds.
// H_for_s_tree is an iterative stand-in tree hash whose latency depends on node parity.

module H_for_s_tree #(
  parameter int R_BASE = 8,
  parameter int R_SKEW = 7
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [511:0] i_msg,
  output logic         o_end,
  output logic [255:0] o_hash
);
  localparam logic [255:0] IV = {8{32'h9E3779B9}};

  logic [511:0] r_msg;
  logic [255:0] r_st;
  logic [4:0]   r_cnt;
  logic         r_run;
  logic         r_end;

  // Odd nodes take R_SKEW extra rounds, so sibling units finish on different cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_msg <= '0;
      r_st  <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
      r_end <= 1'b0;
    end else begin
      r_end <= 1'b0;
      if (i_start) begin
        r_msg <= i_msg;
        r_st  <= IV;
        r_cnt <= i_msg[104] ? 5'(R_BASE + R_SKEW) : 5'(R_BASE);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_st  <= {r_st[242:0], r_st[255:243]} ^ (r_msg[511:256] + r_msg[255:0]);
        r_msg <= {r_msg[474:0], r_msg[511:475]};
        r_cnt <= r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          r_run <= 1'b0;
          r_end <= 1'b1;
        end
      end
    end
  end

  assign o_end  = r_end;
  assign o_hash = r_st;
endmodule

module seed_tree_reconstruct (
  input  logic          clk,
  input  logic          reset,
  input  logic [127:0]  revealed_l1,
  input  logic [127:0]  revealed_l2,
  input  logic [1:0]    hidden_idx,
  input  logic [255:0]  salt,
  input  logic [7:0]    t,
  input  logic          recon_start,
  output logic [1023:0] seed_star,
  output logic          recon_end,
  output logic          busy
);
  typedef enum logic [1:0] {S_IDLE, S_HASH1, S_HASH2, S_DONE} state_t;

  state_t       r_state;
  logic [127:0] r_l1, r_l2;
  logic [1:0]   r_k;
  logic [255:0] r_salt, r_ha, r_hb;
  logic [7:0]   r_t;
  logic         r_start_ab, r_start_cd;
  logic         r_done_a, r_done_b, r_done_c, r_done_d;

  logic         w_rst_n, w_p;
  logic [7:0]   w_node_a, w_node_b, w_node_c, w_node_d;
  logic [511:0] w_msg_a, w_msg_b, w_msg_c, w_msg_d;
  logic         w_end_a, w_end_b, w_end_c, w_end_d;
  logic [255:0] w_hash_a, w_hash_b, w_hash_c, w_hash_d;
  logic         w_seen_a, w_seen_b, w_seen_c, w_seen_d;
  logic [255:0] w_slot [4];
  logic [1023:0] w_star;

  function automatic logic [511:0] f_msg(input logic [127:0] seed, input logic [255:0] s,
                                         input logic [7:0] tt, input logic [7:0] n);
    return {8'h01, seed, s, tt, n, 8'h80, 32'h0, 64'h198};
  endfunction

  assign w_rst_n  = ~reset;
  assign w_p      = r_k[1];
  assign w_node_a = 8'd2 - {7'd0, w_p};
  assign w_node_b = 8'd3 + {6'd0, r_k ^ 2'b01};
  assign w_node_c = (w_node_a << 1) + 8'd1;
  assign w_node_d = (w_node_a << 1) + 8'd2;

  assign w_msg_a = f_msg(r_l1, r_salt, r_t, w_node_a);
  assign w_msg_b = f_msg(r_l2, r_salt, r_t, w_node_b);
  assign w_msg_c = f_msg(r_ha[255:128], r_salt, r_t, w_node_c);
  assign w_msg_d = f_msg(r_ha[127:0], r_salt, r_t, w_node_d);

  H_for_s_tree u_a (.i_clk(clk), .i_rst_n(w_rst_n), .i_start(r_start_ab), .i_msg(w_msg_a), .o_end(w_end_a), .o_hash(w_hash_a));
  H_for_s_tree u_b (.i_clk(clk), .i_rst_n(w_rst_n), .i_start(r_start_ab), .i_msg(w_msg_b), .o_end(w_end_b), .o_hash(w_hash_b));
  H_for_s_tree u_c (.i_clk(clk), .i_rst_n(w_rst_n), .i_start(r_start_cd), .i_msg(w_msg_c), .o_end(w_end_c), .o_hash(w_hash_c));
  H_for_s_tree u_d (.i_clk(clk), .i_rst_n(w_rst_n), .i_start(r_start_cd), .i_msg(w_msg_d), .o_end(w_end_d), .o_hash(w_hash_d));

  assign w_seen_a = r_done_a | w_end_a;
  assign w_seen_b = r_done_b | w_end_b;
  assign w_seen_c = r_done_c | w_end_c;
  assign w_seen_d = r_done_d | w_end_d;

  // Hidden leaf slot keeps its zero default; C/D cover the subtree opposite the hidden one.
  always_comb begin
    for (int s = 0; s < 4; s++) w_slot[s] = '0;
    w_slot[r_k ^ 2'b01]     = r_hb;
    w_slot[{~w_p, 1'b0}]    = w_hash_c;
    w_slot[{~w_p, 1'b1}]    = w_hash_d;
  end
  assign w_star = {w_slot[0], w_slot[1], w_slot[2], w_slot[3]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_l1       <= '0;
      r_l2       <= '0;
      r_k        <= '0;
      r_salt     <= '0;
      r_t        <= '0;
      r_ha       <= '0;
      r_hb       <= '0;
      r_start_ab <= 1'b0;
      r_start_cd <= 1'b0;
      r_done_a   <= 1'b0;
      r_done_b   <= 1'b0;
      r_done_c   <= 1'b0;
      r_done_d   <= 1'b0;
      seed_star  <= '0;
      recon_end  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_start_ab <= 1'b0;
      r_start_cd <= 1'b0;
      if (!recon_start) recon_end <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (recon_start && !recon_end) begin
            r_l1       <= revealed_l1;
            r_l2       <= revealed_l2;
            r_k        <= hidden_idx;
            r_salt     <= salt;
            r_t        <= t;
            r_done_a   <= 1'b0;
            r_done_b   <= 1'b0;
            r_start_ab <= 1'b1;
            busy       <= 1'b1;
            r_state    <= S_HASH1;
          end
        end
        S_HASH1: begin
          if (w_seen_a && w_seen_b) begin
            r_ha       <= w_hash_a;
            r_hb       <= w_hash_b;
            r_done_a   <= 1'b0;
            r_done_b   <= 1'b0;
            r_done_c   <= 1'b0;
            r_done_d   <= 1'b0;
            r_start_cd <= 1'b1;
            r_state    <= S_HASH2;
          end else begin
            r_done_a <= w_seen_a;
            r_done_b <= w_seen_b;
          end
        end
        S_HASH2: begin
          if (w_seen_c && w_seen_d) begin
            r_done_c <= 1'b0;
            r_done_d <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_done_c <= w_seen_c;
            r_done_d <= w_seen_d;
          end
        end
        default: begin
          seed_star <= w_star;
          recon_end <= 1'b1;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seed_tree_reconstruct.sv
// tb/tb_seed_tree_reconstruct.sv - randomized bench against a full prover-side tree expansion model.
module tb_seed_tree_reconstruct;
  localparam int R_EVEN = 8;
  localparam int R_ODD  = 15;
  localparam logic [511:0] MSG_PIN = 512'h01_00000000_00000000_00000000_00000001_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_05_03_80_00000000_00000000_00000198;

  logic          clk = 1'b0;
  logic          reset;
  logic [127:0]  revealed_l1, revealed_l2;
  logic [1:0]    hidden_idx;
  logic [255:0]  salt;
  logic [7:0]    t;
  logic          recon_start;
  logic [1023:0] seed_star;
  logic          recon_end, busy;

  int checks = 0;
  int failures = 0;
  logic          chk_en = 1'b0;
  logic [1023:0] exp_star = '0;
  logic          exp_busy = 1'b0;
  logic          exp_end = 1'b0;

  always #5 clk = ~clk;

  seed_tree_reconstruct dut (
    .clk(clk), .reset(reset), .revealed_l1(revealed_l1), .revealed_l2(revealed_l2),
    .hidden_idx(hidden_idx), .salt(salt), .t(t), .recon_start(recon_start),
    .seed_star(seed_star), .recon_end(recon_end), .busy(busy)
  );

  function automatic logic [511:0] m_msg(input logic [127:0] seed, input logic [255:0] s,
                                         input logic [7:0] tt, input logic [7:0] n);
    return {8'h01, seed, s, tt, n, 8'h80, 32'h0, 64'h198};
  endfunction

  function automatic int m_rounds(input int n);
    return (n % 2 == 1) ? R_ODD : R_EVEN;
  endfunction

  function automatic logic [255:0] m_hash(input logic [511:0] msg);
    logic [255:0] st;
    logic [511:0] m;
    int rounds;
    st = {8{32'h9E3779B9}};
    m = msg;
    rounds = m_rounds(int'(msg[111:104]));
    for (int r = 0; r < rounds; r++) begin
      st = {st[242:0], st[255:243]} ^ (m[511:256] + m[255:0]);
      m = {m[474:0], m[511:475]};
    end
    return st;
  endfunction

  // Expand the whole tree from the root as the prover would, then open it at leaf k.
  task automatic model(input logic [127:0] root, input logic [1:0] k, input logic [255:0] sl,
                       input logic [7:0] tt, output logic [127:0] l1, output logic [127:0] l2,
                       output logic [1023:0] star, output int n_end);
    logic [127:0] s [7];
    logic [255:0] h;
    logic [255:0] leaf [4];
    int p, kk, na, nb, nc, rab, rcd;
    s[0] = root;
    for (int n = 0; n < 3; n++) begin
      h = m_hash(m_msg(s[n], sl, tt, 8'(n)));
      s[2*n+1] = h[255:128];
      s[2*n+2] = h[127:0];
    end
    for (int j = 0; j < 4; j++) leaf[j] = m_hash(m_msg(s[3+j], sl, tt, 8'(3+j)));
    kk = int'(k);
    p = kk / 2;
    leaf[kk] = '0;
    star = {leaf[0], leaf[1], leaf[2], leaf[3]};
    na = 2 - p;
    nb = 3 + (kk ^ 1);
    nc = 2 * na + 1;
    l1 = s[na];
    l2 = s[nb];
    rab = (m_rounds(na) > m_rounds(nb)) ? m_rounds(na) : m_rounds(nb);
    rcd = (m_rounds(nc) > m_rounds(nc + 1)) ? m_rounds(nc) : m_rounds(nc + 1);
    n_end = 3 + (rab + 1) + (rcd + 1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL busy t=%0t: got %b want %b", $time, busy, exp_busy);
      end
      checks++;
      if (recon_end !== exp_end) begin
        failures++;
        $display("FAIL recon_end t=%0t: got %b want %b", $time, recon_end, exp_end);
      end
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (seed_star[1023-256*j -: 256] !== exp_star[1023-256*j -: 256]) begin
          failures++;
          $display("FAIL seed_star slot%0d t=%0t: got %h want %h", j, $time,
                   seed_star[1023-256*j -: 256], exp_star[1023-256*j -: 256]);
        end
      end
    end
  end

  task automatic run(input logic [127:0] root, input logic [1:0] k, input logic [255:0] sl,
                     input logic [7:0] tt, input int hold, input bit drop_mid,
                     input bit perturb, input int rst_at);
    logic [127:0] l1, l2;
    logic [1023:0] star;
    int n_end;
    logic ps;
    model(root, k, sl, tt, l1, l2, star, n_end);
    @(negedge clk);
    revealed_l1 = l1;
    revealed_l2 = l2;
    hidden_idx = k;
    salt = sl;
    t = tt;
    recon_start = 1'b1;
    ps = 1'b1;
    for (int i = 0; i <= n_end + hold; i++) begin
      ps = recon_start;
      @(posedge clk);
      #1;
      exp_busy = (i < n_end);
      if (i == n_end) begin
        exp_end = 1'b1;
        exp_star = star;
      end else if (i > n_end) begin
        exp_end = exp_end && ps;
      end
      if (perturb && i == 3) begin
        revealed_l1 = {$urandom, $urandom, $urandom, $urandom};
        revealed_l2 = {$urandom, $urandom, $urandom, $urandom};
        salt = {8{$urandom}};
        t = 8'($urandom);
        hidden_idx = 2'($urandom);
      end
      if (drop_mid && i == 2) recon_start = 1'b0;
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        checks++;
        if (seed_star !== '0 || recon_end !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL async_reset: got end=%b busy=%b star_nonzero=%b want 0 0 0",
                   recon_end, busy, |seed_star);
        end
        exp_star = '0;
        exp_busy = 1'b0;
        exp_end = 1'b0;
        recon_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
    end
    recon_start = 1'b0;
    ps = 1'b0;
    @(posedge clk);
    #1;
    exp_end = 1'b0;
    exp_busy = 1'b0;
    checks++;
    if (seed_star[1023-256*int'(k) -: 256] !== 256'h0) begin
      failures++;
      $display("FAIL hidden_slot k=%0d: got %h want 0", k, seed_star[1023-256*int'(k) -: 256]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    logic [127:0] l1, l2;
    logic [1023:0] star;
    int n_end;
    reset = 1'b0;
    revealed_l1 = '0;
    revealed_l2 = '0;
    hidden_idx = '0;
    salt = '0;
    t = '0;
    recon_start = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (seed_star !== '0 || recon_end !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got end=%b busy=%b star_nonzero=%b want 0 0 0",
               recon_end, busy, |seed_star);
    end

    checks++;
    if (m_msg(128'h1, 256'h0, 8'h05, 8'h03) !== MSG_PIN) begin
      failures++;
      $display("FAIL pin_msg_layout: got %h want %h", m_msg(128'h1, 256'h0, 8'h05, 8'h03), MSG_PIN);
    end
    model(128'h0, 2'd0, 256'h0, 8'h00, l1, l2, star, n_end);
    checks++;
    if (n_end != 28) begin
      failures++;
      $display("FAIL pin_latency_k0: got %0d want 28", n_end);
    end
    model(128'h0, 2'd2, 256'h0, 8'h00, l1, l2, star, n_end);
    checks++;
    if (n_end != 35) begin
      failures++;
      $display("FAIL pin_latency_k2: got %0d want 35", n_end);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    run(128'h0, 2'd0, 256'h0, 8'h00, 0, 1'b0, 1'b0, -1);
    for (int k = 1; k < 4; k++) run(128'h0, 2'(k), {8{32'hDEADBEEF}}, 8'h05, 0, 1'b0, 1'b0, -1);
    run(128'h0, 2'd1, {8{32'hDEADBEEF}}, 8'h05, 20, 1'b0, 1'b0, -1);
    run(128'h1234, 2'd3, {8{32'h0BADF00D}}, 8'h11, 0, 1'b1, 1'b0, -1);
    run(128'h5678, 2'd2, {8{32'hCAFEBABE}}, 8'h22, 2, 1'b0, 1'b1, -1);
    run(128'h9ABC, 2'd1, {8{32'h01020304}}, 8'h33, 0, 1'b0, 1'b0, 32);
    repeat (2) @(posedge clk);
    run(128'h0, 2'd2, {8{32'hDEADBEEF}}, 8'h05, 0, 1'b0, 1'b0, -1);
    for (int r = 0; r < 6; r++) begin
      run({$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)),
          {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
          8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), -1);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
